// File: rtl/risc_v_32_result_pipe_if.sv
// Data-memory bus between the result pipe (master) and the memory (slave).
interface risc_v_32_result_pipe_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/risc_v_32_result_pipe.sv
// EX/MEM and MEM/WB stages of a RV32 core: data-memory access with
// wait-state stalling, timeout abort, load extraction and forwarding taps.
module risc_v_32_result_pipe #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_store_data,
    risc_v_32_result_pipe_if.master dmem,
    output logic        exmem_wreg,
    output logic [4:0]  exmem_rd,
    output logic [31:0] exmem_result,
    output logic        memwb_wreg,
    output logic [4:0]  memwb_rd,
    output logic [31:0] memwb_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall,
    output logic        mem_err
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state;
    logic [CW-1:0] r_wait_cnt;

    logic        r_em_valid;
    logic        r_em_wreg;
    logic [4:0]  r_em_rd;
    logic [31:0] r_em_result;
    logic        r_em_load;
    logic        r_em_store;
    logic [2:0]  r_em_f3;
    logic [31:0] r_em_sdata;

    logic        r_wb_wreg;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic        w_mem;
    logic        w_bad;
    logic        w_timeout;
    logic        w_req;
    logic        w_stall;
    logic        w_err;
    logic [1:0]  w_ofs;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;

    assign w_ofs = r_em_result[1:0];
    assign w_mem = r_em_valid & (r_em_load | r_em_store);

    // Alignment and funct3 legality of the memory op held in EX/MEM
    always_comb begin
        w_bad = 1'b0;
        if (r_em_load) begin
            case (r_em_f3)
                3'b000, 3'b100: w_bad = 1'b0;
                3'b001, 3'b101: w_bad = w_ofs[0];
                3'b010:         w_bad = |w_ofs;
                default:        w_bad = 1'b1;
            endcase
        end else if (r_em_store) begin
            case (r_em_f3)
                3'b000:  w_bad = 1'b0;
                3'b001:  w_bad = w_ofs[0];
                3'b010:  w_bad = |w_ofs;
                default: w_bad = 1'b1;
            endcase
        end
    end

    assign w_timeout = (r_state == S_WAIT)
                     & (r_wait_cnt == CW'(WAIT_MAX))
                     & !dmem.dmem_ready;
    assign w_req     = w_mem & !w_bad & !w_timeout;
    assign w_stall   = w_req & !dmem.dmem_ready;
    assign w_err     = (w_mem & w_bad) | w_timeout;

    always_comb begin
        w_byte = dmem.dmem_rdata[7:0];
        case (w_ofs)
            2'd0: w_byte = dmem.dmem_rdata[7:0];
            2'd1: w_byte = dmem.dmem_rdata[15:8];
            2'd2: w_byte = dmem.dmem_rdata[23:16];
            2'd3: w_byte = dmem.dmem_rdata[31:24];
            default: w_byte = dmem.dmem_rdata[7:0];
        endcase
        w_half = w_ofs[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (r_em_f3)
            3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ldata = {24'd0, w_byte};
            3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
            3'b101:  w_ldata = {16'd0, w_half};
            default: w_ldata = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_em_sdata;
        if (r_em_store) begin
            case (r_em_f3)
                3'b000: begin
                    w_be    = 4'b0001 << w_ofs;
                    w_wdata = {4{r_em_sdata[7:0]}};
                end
                3'b001: begin
                    w_be    = 4'b0011 << {w_ofs[1], 1'b0};
                    w_wdata = {2{r_em_sdata[15:0]}};
                end
                default: w_be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && !dmem.dmem_ready) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ready || w_timeout) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_em_valid  <= 1'b0;
            r_em_wreg   <= 1'b0;
            r_em_rd     <= '0;
            r_em_result <= '0;
            r_em_load   <= 1'b0;
            r_em_store  <= 1'b0;
            r_em_f3     <= '0;
            r_em_sdata  <= '0;
        end else if (!w_stall) begin
            r_em_valid  <= ex_valid;
            r_em_wreg   <= ex_valid & ex_wreg & (|ex_rd) & !ex_is_store;
            r_em_rd     <= ex_rd;
            r_em_result <= ex_result;
            r_em_load   <= ex_is_load;
            r_em_store  <= ex_is_store;
            r_em_f3     <= ex_funct3;
            r_em_sdata  <= ex_store_data;
        end
    end

    // A stalled cycle pushes a bubble so the writeback port stays quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_wreg <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else if (w_stall) begin
            r_wb_wreg <= 1'b0;
        end else begin
            r_wb_wreg <= r_em_valid & r_em_wreg & !w_err;
            r_wb_rd   <= r_em_rd;
            r_wb_data <= r_em_load ? w_ldata : r_em_result;
        end
    end

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = r_em_store;
    assign dmem.dmem_addr  = {r_em_result[31:2], 2'b00};
    assign dmem.dmem_wdata = w_wdata;
    assign dmem.dmem_be    = w_be;

    assign exmem_wreg   = r_em_valid & r_em_wreg & !r_em_load;
    assign exmem_rd     = r_em_rd;
    assign exmem_result = r_em_result;
    assign memwb_wreg   = r_wb_wreg;
    assign memwb_rd     = r_wb_rd;
    assign memwb_data   = r_wb_data;
    assign rf_we        = r_wb_wreg;
    assign rf_waddr     = r_wb_rd;
    assign rf_wdata     = r_wb_data;
    assign stall        = w_stall;
    assign mem_err      = w_err;
endmodule

// File: tb/tb_risc_v_32_result_pipe.sv
// Directed bench for risc_v_32_result_pipe with a writeback scoreboard.
module tb_risc_v_32_result_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_result = '0;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_store_data = '0;
    logic        exmem_wreg;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_wreg;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall;
    logic        mem_err;

    int total = 0;
    int bad = 0;
    logic [36:0] sb[$];

    risc_v_32_result_pipe_if dmem_if ();

    risc_v_32_result_pipe #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wreg(ex_wreg),
        .ex_result(ex_result), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
        .ex_store_data(ex_store_data),
        .dmem(dmem_if.master),
        .exmem_wreg(exmem_wreg), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_wreg(memwb_wreg), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall(stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] res,
                         input logic wr, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] sd);
        ex_valid      = 1'b1;
        ex_rd         = rd;
        ex_result     = res;
        ex_wreg       = wr;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_funct3     = f3;
        ex_store_data = sd;
    endtask

    task automatic nop();
        ex_valid    = 1'b0;
        ex_wreg     = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
    endtask

    // Monitor: every register-file write must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write rd=%0d data=%h want=none",
                         rf_waddr, rf_wdata);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("wb_rd", 32'(rf_waddr), 32'(e[36:32]));
                chk("wb_data", rf_wdata, e[31:0]);
            end
        end
    end

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        wr;
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] exp;
        logic        pw;
    } vec_t;

    vec_t tv[11] = '{
        '{5'd1,  32'h100,      1'b1, 1'b1, 3'b000, 32'hFFFFFFA5, 1'b1},
        '{5'd2,  32'h100,      1'b1, 1'b1, 3'b100, 32'h000000A5, 1'b1},
        '{5'd3,  32'h101,      1'b1, 1'b1, 3'b100, 32'h000000F0, 1'b1},
        '{5'd4,  32'h102,      1'b1, 1'b1, 3'b000, 32'h00000065, 1'b1},
        '{5'd5,  32'h100,      1'b1, 1'b1, 3'b001, 32'hFFFFF0A5, 1'b1},
        '{5'd6,  32'h102,      1'b1, 1'b1, 3'b101, 32'h00008765, 1'b1},
        '{5'd7,  32'h102,      1'b1, 1'b1, 3'b001, 32'hFFFF8765, 1'b1},
        '{5'd8,  32'h104,      1'b1, 1'b1, 3'b010, 32'h8765F0A5, 1'b1},
        '{5'd0,  32'h55,       1'b1, 1'b0, 3'b000, 32'h0,        1'b0},
        '{5'd10, 32'hDEADBEEF, 1'b0, 1'b0, 3'b000, 32'h0,        1'b0},
        '{5'd11, 32'hCAFEF00D, 1'b1, 1'b0, 3'b000, 32'hCAFEF00D, 1'b1}
    };

    initial begin
        int n;
        dmem_if.dmem_ready = 1'b1;
        dmem_if.dmem_rdata = '0;
        tick();
        tick();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_if.dmem_req), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_exmem_wreg", 32'(exmem_wreg), 32'd0);
        chk("rst_memwb_wreg", 32'(memwb_wreg), 32'd0);
        rst = 1'b0;
        tick();

        // ALU op through both stages
        issue(5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
        sb.push_back({5'd5, 32'h1234});
        tick();
        nop();
        chk("alu_exmem_wreg", 32'(exmem_wreg), 32'd1);
        chk("alu_exmem_rd", 32'(exmem_rd), 32'd5);
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_rf_we", 32'(rf_we), 32'd1);
        chk("alu_rf_wdata", rf_wdata, 32'h1234);
        chk("alu_stall2", 32'(stall), 32'd0);

        // LB with three wait states
        dmem_if.dmem_ready = 1'b0;
        issue(5'd7, 32'h103, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0);
        sb.push_back({5'd7, 32'hFFFFFF80});
        tick();
        nop();
        for (int k = 0; k < 3; k++) begin
            chk("lb_stall", 32'(stall), 32'd1);
            chk("lb_exmem_wreg", 32'(exmem_wreg), 32'd0);
            chk("lb_addr", dmem_if.dmem_addr, 32'h100);
            chk("lb_memwb_bubble", 32'(memwb_wreg), 32'd0);
            tick();
        end
        dmem_if.dmem_ready = 1'b1;
        dmem_if.dmem_rdata = 32'h80000000;
        #1;
        chk("lb_stall_end", 32'(stall), 32'd0);
        tick();
        chk("lb_rf_wdata", rf_wdata, 32'hFFFFFF80);
        tick();

        // SH and SB lane steering
        issue(5'd9, 32'h102, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000ABCD);
        tick();
        nop();
        chk("sh_req", 32'(dmem_if.dmem_req), 32'd1);
        chk("sh_we", 32'(dmem_if.dmem_we), 32'd1);
        chk("sh_be", 32'(dmem_if.dmem_be), 32'hC);
        chk("sh_wdata", dmem_if.dmem_wdata, 32'hABCDABCD);
        chk("sh_exmem_wreg", 32'(exmem_wreg), 32'd0);
        issue(5'd9, 32'h101, 1'b1, 1'b0, 1'b1, 3'b000, 32'h00000012);
        tick();
        nop();
        chk("sb_be", 32'(dmem_if.dmem_be), 32'h2);
        chk("sb_wdata", dmem_if.dmem_wdata, 32'h12121212);
        tick();
        chk("st_rf_we", 32'(rf_we), 32'd0);
        tick();

        // Misaligned LW and undefined store funct3
        dmem_if.dmem_ready = 1'b0;
        issue(5'd3, 32'h101, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
        tick();
        issue(5'd3, 32'h100, 1'b0, 1'b0, 1'b1, 3'b011, 32'h0);
        chk("mis_req", 32'(dmem_if.dmem_req), 32'd0);
        chk("mis_err", 32'(mem_err), 32'd1);
        chk("mis_stall", 32'(stall), 32'd0);
        tick();
        nop();
        chk("bad_f3_err", 32'(mem_err), 32'd1);
        chk("mis_rf_we", 32'(rf_we), 32'd0);
        tick();
        chk("mis_err_end", 32'(mem_err), 32'd0);
        tick();

        // LW timeout with ready held low
        issue(5'd6, 32'h200, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
        tick();
        nop();
        n = 0;
        while (stall && n < 20) begin
            n++;
            tick();
        end
        chk("to_stall_cycles", 32'(n), 32'd4);
        chk("to_err", 32'(mem_err), 32'd1);
        tick();
        chk("to_err_end", 32'(mem_err), 32'd0);
        chk("to_rf_we", 32'(rf_we), 32'd0);
        tick();

        // Back-to-back zero-wait stream
        dmem_if.dmem_ready = 1'b1;
        dmem_if.dmem_rdata = 32'h8765F0A5;
        foreach (tv[i]) begin
            issue(tv[i].rd, tv[i].res, tv[i].wr, tv[i].ld, 1'b0,
                  tv[i].f3, 32'h0);
            if (tv[i].pw)
                sb.push_back({tv[i].rd, tv[i].exp});
            tick();
            chk("stream_stall", 32'(stall), 32'd0);
        end
        nop();
        tick();
        tick();

        // Reset during the second WAIT cycle
        dmem_if.dmem_ready = 1'b0;
        issue(5'd4, 32'h300, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
        tick();
        nop();
        tick();
        tick();
        chk("rw_stall_before", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        chk("rw_req", 32'(dmem_if.dmem_req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        chk("rw_wait_cnt", 32'(dut.r_wait_cnt), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("rw_rf_we", 32'(rf_we), 32'd0);
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
